// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : set-2 byte constants, sequencer state encoding and key event type.
// Rev 1.0 - initial release
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_PAUSE_KEY = 8'h77;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E0   = 3'd1,
    ST_F0   = 3'd2,
    ST_E0F0 = 3'd3,
    ST_SKIP = 3'd4
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_error_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

  // E0 12 / E0 59 are the fake shifts sent around extended keys.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// ps2_event_fifo : first-word fall-through FIFO of 10-bit key events.
// Rev 1.0 - initial release
// ============================================================================
module ps2_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [9:0]             data_i,
  input  logic                   pop_i,
  output logic [9:0]             head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [9:0]    mem_q [DEPTH];
  logic          w_pop, w_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// ps2_key_sequencer : folds set-2 prefixes into key events, buffers them and
// throttles the keyboard. Optional Pause decoding under PS2_PAUSE_SEQ_EN.
// Rev 1.0 - initial release
// ============================================================================
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 28000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] scancode,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  input  logic       key_ready,
  output logic       ps2_clk_inhibit,
  output logic       kbd_bat,
  output logic       kbd_error,
  output logic       overrun
);
  import ps2_pkg::*;

  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int            TW          = $clog2(PREFIX_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST     = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [CW-1:0] INHIBIT_LVL = CW'(FIFO_DEPTH - 1);

  ps2_state_t    state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          w_timeout;
  logic          w_push, bat_d, err_d;
  key_event_t    w_evt;
  logic          bat_q, err_q, inhibit_q, overrun_q;
  logic          w_pop, w_push_ok, w_empty, w_full;
  logic [CW-1:0] w_count, w_count_next;
  logic [9:0]    w_head;
`ifdef PS2_PAUSE_SEQ_EN
  logic [2:0]    skip_cnt_q, skip_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

`ifdef PS2_PAUSE_SEQ_EN
  always_ff @(posedge clk) begin
    if (reset) skip_cnt_q <= '0;
    else       skip_cnt_q <= skip_cnt_d;
  end
`endif

  // A received byte always outranks the timeout, even on the last count.
  assign w_timeout = (state_q != ST_IDLE) && !rx_done && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = (state_q == ST_IDLE || rx_done || w_timeout) ? '0 : to_cnt_q + 1'b1;
`ifdef PS2_PAUSE_SEQ_EN
    skip_cnt_d = (state_q == ST_SKIP) ? skip_cnt_q + {2'b00, rx_done} : 3'd0;
`endif
    if (rx_done) begin
      if (is_error_byte(scancode)) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (scancode == PS2_PFX_EXT)      state_d = ST_E0;
            else if (scancode == PS2_PFX_REL) state_d = ST_F0;
`ifdef PS2_PAUSE_SEQ_EN
            else if (scancode == PS2_PFX_PAUSE) state_d = ST_SKIP;
`endif
          end
          ST_E0:   state_d = (scancode == PS2_PFX_REL) ? ST_E0F0 : ST_IDLE;
`ifdef PS2_PAUSE_SEQ_EN
          ST_SKIP: if (skip_cnt_q == 3'd6) state_d = ST_IDLE;
`endif
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (w_timeout) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    w_push = 1'b0;
    w_evt  = '0;
    bat_d  = 1'b0;
    err_d  = 1'b0;
    if (rx_done) begin
      if (is_error_byte(scancode)) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            case (scancode)
              PS2_PFX_EXT, PS2_PFX_REL, PS2_ACK, PS2_RESEND, PS2_ECHO: ;
`ifdef PS2_PAUSE_SEQ_EN
              PS2_PFX_PAUSE: ;
`endif
              PS2_BAT_OK: bat_d = 1'b1;
              default: begin
                w_push = 1'b1;
                w_evt  = '{ext: 1'b0, rel: 1'b0, code: scancode};
              end
            endcase
          end
          ST_E0: begin
            w_push = (scancode != PS2_PFX_REL) && !is_fake_shift(scancode);
            w_evt  = '{ext: 1'b1, rel: 1'b0, code: scancode};
          end
          ST_F0: begin
            w_push = 1'b1;
            w_evt  = '{ext: 1'b0, rel: 1'b1, code: scancode};
          end
          ST_E0F0: begin
            w_push = !is_fake_shift(scancode);
            w_evt  = '{ext: 1'b1, rel: 1'b1, code: scancode};
          end
`ifdef PS2_PAUSE_SEQ_EN
          ST_SKIP: begin
            w_push = (skip_cnt_q == 3'd6);
            w_evt  = '{ext: 1'b1, rel: 1'b0, code: PS2_PAUSE_KEY};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .data_i  (w_evt),
    .pop_i   (key_ready),
    .head_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

  assign w_pop        = key_ready && !w_empty;
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_count_next = w_count + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      bat_q     <= 1'b0;
      err_q     <= 1'b0;
      inhibit_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bat_q     <= bat_d;
      err_q     <= err_d;
      inhibit_q <= (w_count_next >= INHIBIT_LVL);
      if (w_push && w_full && !w_pop) overrun_q <= 1'b1;
    end
  end

  assign key_valid       = !w_empty;
  assign key_ext         = w_head[9];
  assign key_release     = w_head[8];
  assign key_code        = w_head[7:0];
  assign ps2_clk_inhibit = inhibit_q;
  assign kbd_bat         = bat_q;
  assign kbd_error       = err_q;
  assign overrun         = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ps2_key_sequencer : directed bytes checked against a queue-based model.
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_key_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 28000;

  logic       clk = 1'b0, reset = 1'b1, rx_done = 1'b0, key_ready = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       key_valid, key_ext, key_release, ps2_clk_inhibit, kbd_bat, kbd_error, overrun;
  logic [7:0] key_code;

  int compared = 0;
  int mismatched = 0;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .scancode(scancode),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_ready(key_ready),
    .ps2_clk_inhibit(ps2_clk_inhibit), .kbd_bat(kbd_bat),
    .kbd_error(kbd_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending-prefix flags, a byte-gap timer and an event queue.
  logic [9:0] mq[$];
  logic [9:0] dut_pops[$];
  logic       m_bat = 0, m_err = 0, m_ovr = 0, m_inh = 0;
  bit         pend_ext = 0, pend_rel = 0, model_live = 0;
  int         skip_left = 0;
  longint     cyc = 0, last_cyc = 0;

  always @(posedge clk) begin
    logic [9:0] ev;
    logic [7:0] b;
    bit do_push, do_pop;
    cyc++;
    m_bat = 0;
    m_err = 0;
    if (reset) begin
      mq.delete();
      m_ovr = 0; m_inh = 0;
      pend_ext = 0; pend_rel = 0; skip_left = 0;
      model_live = 1;
    end else begin
      do_push = 0;
      ev = '0;
      do_pop = key_ready && (mq.size() != 0);
      if (rx_done) begin
        if ((pend_ext || pend_rel || skip_left != 0) && (cyc - last_cyc) > TMO) begin
          pend_ext = 0; pend_rel = 0; skip_left = 0;
        end
        last_cyc = cyc;
        b = scancode;
        if (b == 8'h00 || b == 8'hFF) begin
          m_err = 1; pend_ext = 0; pend_rel = 0; skip_left = 0;
        end else if (skip_left != 0) begin
          skip_left--;
          if (skip_left == 0) begin do_push = 1; ev = {2'b10, 8'h77}; end
        end else if (pend_rel) begin
          do_push = !(pend_ext && (b == 8'h12 || b == 8'h59));
          ev = {pend_ext, 1'b1, b};
          pend_ext = 0; pend_rel = 0;
        end else if (pend_ext) begin
          if (b == 8'hF0) pend_rel = 1;
          else begin
            do_push = !(b == 8'h12 || b == 8'h59);
            ev = {2'b10, b};
            pend_ext = 0;
          end
        end else begin
          case (b)
            8'hE0: pend_ext = 1;
            8'hF0: pend_rel = 1;
            8'hAA: m_bat = 1;
            8'hFA, 8'hFE, 8'hEE: ;
`ifdef PS2_PAUSE_SEQ_EN
            8'hE1: skip_left = 7;
`endif
            default: begin do_push = 1; ev = {2'b00, b}; end
          endcase
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovr = 1;
      end
      m_inh = (mq.size() >= DEPTH - 1);
    end
    if (!reset && key_valid && key_ready) dut_pops.push_back({key_ext, key_release, key_code});
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("key_valid", {31'd0, key_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("head", {22'd0, key_ext, key_release, key_code}, {22'd0, mq[0]});
      chk("inhibit", {31'd0, ps2_clk_inhibit}, {31'd0, m_inh});
      chk("kbd_bat", {31'd0, kbd_bat}, {31'd0, m_bat});
      chk("kbd_error", {31'd0, kbd_error}, {31'd0, m_err});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    rx_done = 1'b1; scancode = b;
    @(posedge clk); #2;
    rx_done = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic check_ev(input string name, input logic [9:0] exp);
    chk({name, "_valid"}, {31'd0, key_valid}, 32'd1);
    chk(name, {22'd0, key_ext, key_release, key_code}, {22'd0, exp});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {24'd0, key_code}, 32'd0);
    chk("rst_flags", {26'd0, key_ext, key_release, ps2_clk_inhibit, kbd_bat, kbd_error, overrun}, 32'd0);
    key_ready = 1'b1;

    send(8'h1C);                    check_ev("make_1C", {2'b00, 8'h1C});
    send(8'hF0); send(8'h1C);       check_ev("brk_1C", {2'b01, 8'h1C});
    send(8'hE0); send(8'h75);       check_ev("ext_75", {2'b10, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75); check_ev("extbrk_75", {2'b11, 8'h75});
    send(8'hE0); send(8'h12);       chk("fake_shift", {31'd0, key_valid}, 32'd0);

    send(8'hF0);
    repeat (30000) @(posedge clk);
    send(8'h1C);                    check_ev("timeout_1C", {2'b00, 8'h1C});

    @(posedge clk); #2 key_ready = 1'b0;
    dut_pops.delete();
    send(8'h15); send(8'h16);       chk("inh_after2", {31'd0, ps2_clk_inhibit}, 32'd0);
    send(8'h1E);                    chk("inh_after3", {31'd0, ps2_clk_inhibit}, 32'd1);
    send(8'h26);                    chk("ovr_after4", {31'd0, overrun}, 32'd0);
    send(8'h25);                    chk("ovr_after5", {31'd0, overrun}, 32'd1);
    send(8'h2E);
    @(posedge clk); #2 key_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("drain_n", dut_pops.size(), 32'd4);
    if (dut_pops.size() == 4) begin
      chk("pop0", {22'd0, dut_pops[0]}, 32'h015);
      chk("pop1", {22'd0, dut_pops[1]}, 32'h016);
      chk("pop2", {22'd0, dut_pops[2]}, 32'h01E);
      chk("pop3", {22'd0, dut_pops[3]}, 32'h026);
    end

    reset_dut();
    key_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("full_inh", {31'd0, ps2_clk_inhibit}, 32'd1);
    dut_pops.delete();
    @(posedge clk); #2;
    rx_done = 1'b1; scancode = 8'h05; key_ready = 1'b1;
    @(posedge clk); #2;
    rx_done = 1'b0; key_ready = 1'b0;
    check_ev("pushpop_head", {2'b00, 8'h02});
    chk("pushpop_ovr", {31'd0, overrun}, 32'd0);
    chk("pushpop_inh", {31'd0, ps2_clk_inhibit}, 32'd1);
    key_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("pp_drain_n", dut_pops.size(), 32'd5);
    if (dut_pops.size() == 5) chk("pp_last", {22'd0, dut_pops[4]}, 32'h005);

    send(8'hAA);                    chk("bat_hi", {31'd0, kbd_bat}, 32'd1);
    @(posedge clk); #2;             chk("bat_lo", {31'd0, kbd_bat}, 32'd0);
    send(8'hFF);                    chk("err_hi", {31'd0, kbd_error}, 32'd1);
    @(posedge clk); #2;             chk("err_lo", {31'd0, kbd_error}, 32'd0);
    send(8'hE0); send(8'h00); send(8'h75); check_ev("err_abort", {2'b00, 8'h75});
    send(8'hE0);
    reset_dut();
    key_ready = 1'b1;
    send(8'h75);                    check_ev("rst_mid", {2'b00, 8'h75});

`ifdef PS2_PAUSE_SEQ_EN
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_quiet", {31'd0, key_valid}, 32'd0);
    send(8'h77);                    check_ev("pause", {2'b10, 8'h77});
`else
    send(8'hE1);                    check_ev("e1_plain", {2'b00, 8'hE1});
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
